// File: rtl/cpu_bus_pkg.sv
// Shared CPU data-bus definitions: I/O addresses, status bit positions and UART FSM states.
package cpu_bus_pkg;

  localparam logic [7:0] ADDR_UART_DATA = 8'h01;
  localparam logic [7:0] ADDR_UART_STAT = 8'h02;
  localparam logic [7:0] ADDR_RAM_BASE  = 8'h20;

  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_TX_FULL  = 1;
  localparam int unsigned STAT_TX_IDLE  = 2;
  localparam int unsigned STAT_RX_OVR   = 3;
  localparam int unsigned STAT_TX_OVF   = 4;
  localparam int unsigned STAT_RX_FERR  = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 UART serializer; pulls bytes from a valid/ready source, LSB first.
module uart_tx_ser
  import cpu_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       idle_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BaudMax = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_end;

  assign bit_end = (baud_q == BaudMax);
  assign idle_o  = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_o = 1'b0;
    tx_o    = 1'b1;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = START;
          baud_d  = '0;
          shift_d = data_i;
        end
      end
      START: begin
        tx_o   = 1'b0;
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_o   = shift_q[0];
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          // Accept the next byte here so consecutive frames run with no idle gap.
          baud_d  = '0;
          ready_o = 1'b1;
          if (valid_i) begin
            state_d = START;
            shift_d = data_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU data-port responder: 224-byte RAM at 20h-ffh, UART data (01h) and status (02h) registers.
// Define UART_LOOPBACK_EN to feed the RX deserializer from the internal TX line.
module mem_io_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_addr,
  input  logic       mem_wr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int unsigned AW       = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned RamWords = 224;
  localparam logic [CW-1:0] BaudMax  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BaudHalf = CW'(CLKS_PER_BIT / 2 - 1);

  // Address decode
  logic       wr_uart, wr_stat, wr_ram, is_ram;
  logic [7:0] ram_idx;
  assign is_ram  = (mem_addr >= ADDR_RAM_BASE);
  assign ram_idx = mem_addr - ADDR_RAM_BASE;
  assign wr_uart = mem_wr && (mem_addr == ADDR_UART_DATA);
  assign wr_stat = mem_wr && (mem_addr == ADDR_UART_STAT);
  assign wr_ram  = mem_wr && is_ram;

  logic [7:0] ram_q [RamWords];
  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= wr_data;
  end

  // TX FIFO with one extra pointer bit to tell full from empty
  logic [7:0]  fifo_q [TX_FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop, ser_ready, ser_idle;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_pop   = !fifo_empty && ser_ready;
  assign fifo_push  = wr_uart && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_q[wptr_q[AW-1:0]] <= wr_data;
  end

  uart_tx_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_ser (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(!fifo_empty),
    .data_i (fifo_q[rptr_q[AW-1:0]]),
    .ready_o(ser_ready),
    .tx_o   (uart_tx),
    .idle_o (ser_idle)
  );

  // RX line source
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  logic unused_rx_pin;
  assign rx_src        = uart_tx;
  assign unused_rx_pin = uart_rx;
`else
  assign rx_src = uart_rx;
`endif

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_good, rx_bad;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = START;
          rx_baud_d  = '0;
        end
      end
      START: begin
        rx_baud_d = rx_baud_q + 1'b1;
        if (rx_baud_q == BaudHalf) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        rx_baud_d = rx_baud_q + 1'b1;
        if (rx_baud_q == BaudMax) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        rx_baud_d = rx_baud_q + 1'b1;
        if (rx_baud_q == BaudMax) begin
          rx_baud_d  = '0;
          rx_state_d = IDLE;
          rx_good    = rx_s2_q;
          rx_bad     = !rx_s2_q;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Status: W1C clears apply before new events, so a completing frame can reload rx_valid
  logic       rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic       tx_ovf_q, tx_ovf_d, rx_ferr_q, rx_ferr_d;
  logic [7:0] rx_hold_q, rx_hold_d, clr, status, rd_data_d;

  always_comb begin
    clr        = wr_stat ? wr_data : 8'h00;
    rx_valid_d = rx_valid_q && !clr[STAT_RX_VALID];
    rx_ovr_d   = rx_ovr_q && !clr[STAT_RX_OVR];
    tx_ovf_d   = tx_ovf_q && !clr[STAT_TX_OVF];
    rx_ferr_d  = rx_ferr_q && !clr[STAT_RX_FERR];
    rx_hold_d  = rx_hold_q;
    if (rx_good) begin
      if (rx_valid_d) begin
        rx_ovr_d = 1'b1;
      end else begin
        rx_hold_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
    if (rx_bad) rx_ferr_d = 1'b1;
    if (wr_uart && fifo_full && !fifo_pop) tx_ovf_d = 1'b1;
  end

  always_comb begin
    status                = 8'h00;
    status[STAT_RX_VALID] = rx_valid_q;
    status[STAT_TX_FULL]  = fifo_full;
    status[STAT_TX_IDLE]  = fifo_empty && ser_idle;
    status[STAT_RX_OVR]   = rx_ovr_q;
    status[STAT_TX_OVF]   = tx_ovf_q;
    status[STAT_RX_FERR]  = rx_ferr_q;
    rd_data_d             = 8'h00;
    if (is_ram) rd_data_d = ram_q[ram_idx];
    else if (mem_addr == ADDR_UART_DATA) rd_data_d = rx_hold_q;
    else if (mem_addr == ADDR_UART_STAT) rd_data_d = status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data    <= 8'h00;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_hold_q  <= 8'h00;
    end else begin
      rd_data    <= rd_data_d;
      if (fifo_push) wptr_q <= wptr_q + 1'b1;
      if (fifo_pop) rptr_q <= rptr_q + 1'b1;
      rx_s1_q    <= rx_src;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_hold_q  <= rx_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder; short bit time to keep frames fast.
module tb_mem_io_responder;

  localparam int unsigned Cpb   = 8;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic       mem_wr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       uart_rx;
  logic       uart_tx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mon_q [$];

  mem_io_responder #(
    .CLKS_PER_BIT (Cpb),
    .TX_FIFO_DEPTH(Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_addr(mem_addr),
    .mem_wr  (mem_wr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    mem_addr = a;
    wr_data  = d;
    mem_wr   = 1'b1;
    tick(1);
    mem_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    mem_addr = a;
    tick(1);
    d = rd_data;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(Cpb);
    end
    uart_rx = stop;
    tick(Cpb);
    uart_rx = 1'b1;
    tick(4);
  endtask

  task automatic wait_tx_idle(output logic ok);
    mem_addr = 8'h02;
    ok = 1'b0;
    for (int i = 0; i < 12 * 10 * Cpb; i++) begin
      tick(1);
      if (rd_data[2] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Independent TX line decoder: samples mid-bit and records frames with a valid stop bit
  always begin
    logic [7:0] b;
    @(negedge uart_tx);
    repeat (Cpb / 2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      repeat (Cpb) @(posedge clk);
      #1;
      b[i] = uart_tx;
    end
    repeat (Cpb) @(posedge clk);
    #1;
    if (uart_tx === 1'b1) mon_q.push_back(b);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       ok;
    logic [9:0] frame;
    rst      = 1'b1;
    mem_addr = 8'h00;
    mem_wr   = 1'b0;
    wr_data  = 8'h00;
    uart_rx  = 1'b1;
    #1;
    check_eq("reset_rd", rd_data, 8'h00);
    check_eq("reset_tx", uart_tx, 1'b1);
    tick(3);
    rst = 1'b0;
    bus_rd(8'h02, d);
    check_eq("reset_status", d, 8'h04);

    // 1: RAM and unmapped reads
    bus_wr(8'h20, 8'h5A);
    bus_wr(8'hFF, 8'h3C);
    bus_rd(8'h20, d); check_eq("ram_20", d, 8'h5A);
    bus_rd(8'hFF, d); check_eq("ram_ff", d, 8'h3C);
    bus_rd(8'h00, d); check_eq("rd_00", d, 8'h00);
    bus_rd(8'h10, d); check_eq("rd_10", d, 8'h00);
    bus_wr(8'h30, 8'h11);
    mem_addr = 8'h30; wr_data = 8'h22; mem_wr = 1'b1;
    tick(1);
    check_eq("rdw_old", rd_data, 8'h11);
    mem_wr = 1'b0;
    tick(1);
    check_eq("rdw_new", rd_data, 8'h22);

    // 2: single TX frame waveform; 41h LSB first framed by start/stop
    bus_wr(8'h01, 8'h41);
    mem_addr = 8'h02;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq("tx_start_seen", ok, 1'b1);
    frame = 10'b1_0100_0001_0;
    tick(Cpb / 2);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("tx_bit%0d", i), uart_tx, frame[i]);
      check_eq($sformatf("tx_busy%0d", i), rd_data[2], 1'b0);
      if (i < 9) tick(Cpb);
    end
    tick(Cpb);
    check_eq("tx_idle_after", rd_data[2], 1'b1);

    // 3: overflow while serializer busy
    mon_q.delete();
    bus_wr(8'h01, 8'hAA);
    tick(2);
    for (int i = 0; i < 9; i++) bus_wr(8'h01, 8'(i));
    bus_rd(8'h02, d);
    check_eq("ovf_status", d & 8'h16, 8'h12);
    bus_wr(8'h02, 8'h10);
    bus_rd(8'h02, d);
    check_eq("ovf_cleared", d & 8'h16, 8'h02);
    wait_tx_idle(ok);
    check_eq("drain_idle", ok, 1'b1);
    check_eq("frames_sent", mon_q.size(), 9);
    for (int i = 0; i < 9 && i < mon_q.size(); i++)
      check_eq($sformatf("frame%0d", i), mon_q[i], (i == 0) ? 8'hAA : 8'(i - 1));

`ifndef UART_LOOPBACK_EN
    // 4: RX receive and overrun
    send_rx(8'hC3, 1'b1);
    bus_rd(8'h02, d); check_eq("rx_valid", d, 8'h05);
    bus_rd(8'h01, d); check_eq("rx_byte", d, 8'hC3);
    send_rx(8'h7E, 1'b1);
    bus_rd(8'h02, d); check_eq("rx_ovr", d, 8'h0D);
    bus_rd(8'h01, d); check_eq("rx_keep", d, 8'hC3);
    bus_wr(8'h02, 8'h09);
    bus_rd(8'h02, d);
    check_eq("rx_clr_bits", d & 8'h39, 8'h00);
    check_eq("rx_clr_idle", d[2], 1'b1);

    // 5: framing error then glitch
    send_rx(8'h55, 1'b0);
    bus_rd(8'h02, d); check_eq("rx_ferr", d, 8'h24);
    uart_rx = 1'b0;
    tick(Cpb / 4);
    uart_rx = 1'b1;
    tick(3 * Cpb);
    bus_rd(8'h02, d); check_eq("rx_glitch", d, 8'h24);
`endif

    // 6: reset mid-frame
    bus_wr(8'h01, 8'hF0);
    mem_addr = 8'h20;
    tick(20);
    check_eq("pre_rst_rd", rd_data, 8'h5A);
    rst = 1'b1;
    #1;
    check_eq("rst_tx", uart_tx, 1'b1);
    check_eq("rst_rd", rd_data, 8'h00);
    tick(2);
    rst = 1'b0;
    bus_rd(8'h02, d); check_eq("post_rst_status", d, 8'h04);
    bus_rd(8'h20, d); check_eq("ram_kept", d, 8'h5A);
`ifdef UART_LOOPBACK_EN
    bus_wr(8'h01, 8'h55);
    tick(12 * Cpb + 10);
    bus_rd(8'h01, d); check_eq("loopback", d, 8'h55);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
